// File: rtl/pool_arbiter.sv
// rtl/pool_arbiter.sv - round-robin arbiter sharing one maxpool unit among N_REQ requesters
// Optional WAIT timeout abort enabled by defining POOL_TIMEOUT_EN.
module pool_arbiter #(
    parameter int N_REQ   = 3,
    parameter int GAP     = 5,
    parameter int TIMEOUT = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid_i,
    input  logic [N_REQ*288-1:0]   req_data_i,
    output logic [N_REQ-1:0]       req_ready_o,
    output logic                   mp_valid_o,
    output logic [287:0]           mp_data_o,
    input  logic                   mp_valid_i,
    input  logic [71:0]            mp_data_i,
    output logic                   res_valid_o,
    output logic [71:0]            res_data_o,
    output logic [1:0]             res_id_o,
    output logic                   busy_o,
    output logic                   err_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    localparam int GW = $clog2(GAP);

    state_t         r_state;
    logic [1:0]     r_rr_ptr;
    logic [1:0]     r_winner;
    logic [287:0]   r_hold;
    logic [GW-1:0]  r_gap_cnt;

    logic           w_found;
    logic [1:0]     w_win;
    logic [2:0]     w_idx;
    logic [N_REQ-1:0] w_rot;
    logic [1:0]     w_next_ptr;

    // Scan requesters starting at rr_ptr, wrapping past N_REQ-1 back to 0.
    always_comb begin
        w_found = 1'b0;
        w_win   = 2'd0;
        w_idx   = 3'd0;
        w_rot   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_idx = {1'b0, r_rr_ptr} + 3'(i);
            if (w_idx >= 3'(N_REQ))
                w_idx = w_idx - 3'(N_REQ);
            w_rot = req_valid_i >> w_idx;
            if (!w_found && w_rot[0]) begin
                w_found = 1'b1;
                w_win   = w_idx[1:0];
            end
        end
    end

    assign w_next_ptr = (w_win == 2'(N_REQ - 1)) ? 2'd0 : w_win + 2'd1;
    assign mp_data_o  = r_hold;
    assign busy_o     = (r_state != S_IDLE);

`ifdef POOL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT);
    logic [TW-1:0] r_to_cnt;
    logic          r_err;
    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

    // The IDLE arbitration cycle is the last of the GAP idle cycles, so GAP
    // itself lasts GAP-1 cycles and issue-to-issue spacing is 1 + 13 + GAP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= 2'd0;
            r_winner    <= 2'd0;
            r_hold      <= '0;
            r_gap_cnt   <= '0;
            req_ready_o <= '0;
            mp_valid_o  <= 1'b0;
            res_valid_o <= 1'b0;
            res_data_o  <= '0;
            res_id_o    <= 2'd0;
`ifdef POOL_TIMEOUT_EN
            r_to_cnt    <= '0;
            r_err       <= 1'b0;
`endif
        end else begin
            req_ready_o <= '0;
            mp_valid_o  <= 1'b0;
            res_valid_o <= 1'b0;
`ifdef POOL_TIMEOUT_EN
            r_err       <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state     <= S_ISSUE;
                        r_winner    <= w_win;
                        r_hold      <= req_data_i[32'(w_win)*288 +: 288];
                        req_ready_o <= {{(N_REQ-1){1'b0}}, 1'b1} << w_win;
                        mp_valid_o  <= 1'b1;
                        r_rr_ptr    <= w_next_ptr;
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT;
`ifdef POOL_TIMEOUT_EN
                    r_to_cnt <= '0;
`endif
                end
                S_WAIT: begin
                    if (mp_valid_i) begin
                        res_data_o  <= mp_data_i;
                        res_id_o    <= r_winner;
                        res_valid_o <= 1'b1;
                        r_gap_cnt   <= '0;
                        r_state     <= S_GAP;
                    end
`ifdef POOL_TIMEOUT_EN
                    else if (r_to_cnt == TW'(TIMEOUT - 1)) begin
                        r_err     <= 1'b1;
                        res_id_o  <= r_winner;
                        r_gap_cnt <= '0;
                        r_state   <= S_GAP;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
`endif
                end
                S_GAP: begin
                    if (r_gap_cnt == GW'(GAP - 2))
                        r_state <= S_IDLE;
                    else
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pool_arbiter.sv
// tb/tb_pool_arbiter.sv - directed self-checking bench for pool_arbiter
// Timeout scenario follows POOL_TIMEOUT_EN when it is defined.
module tb_pool_arbiter;

    logic           clk;
    logic           rst_n;
    logic [2:0]     req_valid_i;
    logic [863:0]   req_data_i;
    logic [2:0]     req_ready_o;
    logic           mp_valid_o;
    logic [287:0]   mp_data_o;
    logic           mp_valid_i;
    logic [71:0]    mp_data_i;
    logic           res_valid_o;
    logic [71:0]    res_data_o;
    logic [1:0]     res_id_o;
    logic           busy_o;
    logic           err_o;

    int  checks;
    int  errors;
    int  cyc;
    bit  mp_model_en;

    localparam logic [71:0] RES_R0 = 72'ha39f9b97938f8b8783;
    localparam logic [71:0] RES_R1 = 72'h231f1b17130f0b0703;
    localparam logic [71:0] RES_R2 = 72'h635f5b57534f4b4743;

    pool_arbiter #(.N_REQ(3), .GAP(5), .TIMEOUT(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_ready_o (req_ready_o),
        .mp_valid_o  (mp_valid_o),
        .mp_data_o   (mp_data_o),
        .mp_valid_i  (mp_valid_i),
        .mp_data_i   (mp_data_i),
        .res_valid_o (res_valid_o),
        .res_data_o  (res_data_o),
        .res_id_o    (res_id_o),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [287:0] window(input int r);
        logic [287:0] w;
        w = '0;
        for (int k = 0; k < 36; k++)
            w[k*8 +: 8] = 8'(k + ((r + 2) % 3) * 64);
        return w;
    endfunction

    // Maxpool model: 13-cycle latency, result byte j = max of window bytes 4j..4j+3.
    task automatic mp_model();
        int           cd;
        logic [71:0]  res;
        logic [7:0]   m;
        cd = 0;
        res = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cd = 0;
                mp_valid_i = 1'b0;
            end else if (mp_model_en) begin
                if (mp_valid_i) mp_valid_i = 1'b0;
                if (mp_valid_o) begin
                    for (int j = 0; j < 9; j++) begin
                        m = 8'd0;
                        for (int b = 0; b < 4; b++)
                            if (mp_data_o[(4*j+b)*8 +: 8] > m) m = mp_data_o[(4*j+b)*8 +: 8];
                        res[j*8 +: 8] = m;
                    end
                    cd = 13;
                end else if (cd > 0) begin
                    cd = cd - 1;
                    if (cd == 0) begin
                        mp_valid_i = 1'b1;
                        mp_data_i  = res;
                    end
                end
            end
        end
    endtask

    task automatic wait_sig(input int sel, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            case (sel)
                0: if (req_ready_o != 3'b000) ok = 1'b1;
                1: if (res_valid_o) ok = 1'b1;
                2: if (!busy_o) ok = 1'b1;
                default: if (err_o) ok = 1'b1;
            endcase
            if (ok) break;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if (req_ready_o !== 3'b000 || mp_valid_o !== 1'b0)
            begin errors++; $display("FAIL reset_ready_mpvalid: got %b/%b want 000/0", req_ready_o, mp_valid_o); end
        checks++;
        if (mp_data_o !== 288'd0)
            begin errors++; $display("FAIL reset_mp_data: got %h want 0", mp_data_o); end
        checks++;
        if (res_valid_o !== 1'b0 || res_data_o !== 72'd0 || res_id_o !== 2'd0)
            begin errors++; $display("FAIL reset_result: got %b %h %0d want 0 0 0", res_valid_o, res_data_o, res_id_o); end
        checks++;
        if (busy_o !== 1'b0 || err_o !== 1'b0)
            begin errors++; $display("FAIL reset_busy_err: got %b/%b want 0/0", busy_o, err_o); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        bit ok;
        int t_iss;
        mp_model_en = 1'b1;
        @(negedge clk);
        req_valid_i = 3'b010;
        wait_sig(0, 10, ok);
        t_iss = cyc;
        checks++;
        if (!ok) begin errors++; $display("FAIL single_grant_timeout: got no grant want grant"); end
        checks++;
        if (req_ready_o !== 3'b010)
            begin errors++; $display("FAIL single_grant: got %b want 010", req_ready_o); end
        checks++;
        if (mp_valid_o !== 1'b1)
            begin errors++; $display("FAIL single_mp_valid: got %b want 1", mp_valid_o); end
        checks++;
        if (mp_data_o !== window(1))
            begin errors++; $display("FAIL single_mp_data: got %h want %h", mp_data_o, window(1)); end
        req_valid_i = 3'b000;
        @(negedge clk);
        checks++;
        if (mp_valid_o !== 1'b0 || req_ready_o !== 3'b000)
            begin errors++; $display("FAIL single_pulse_width: got %b/%b want 0/000", mp_valid_o, req_ready_o); end
        checks++;
        if (mp_data_o !== window(1))
            begin errors++; $display("FAIL single_mp_data_hold: got %h want %h", mp_data_o, window(1)); end
        wait_sig(1, 30, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_result_timeout: got no res_valid want res_valid"); end
        checks++;
        if (cyc - t_iss != 14)
            begin errors++; $display("FAIL single_latency: got %0d want 14", cyc - t_iss); end
        checks++;
        if (res_id_o !== 2'd1 || res_data_o !== RES_R1)
            begin errors++; $display("FAIL single_result: got id %0d data %h want id 1 data %h", res_id_o, res_data_o, RES_R1); end
        @(negedge clk);
        checks++;
        if (res_valid_o !== 1'b0 || busy_o !== 1'b1)
            begin errors++; $display("FAIL single_res_pulse: got %b busy %b want 0 busy 1", res_valid_o, busy_o); end
        wait_sig(2, 20, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_idle_timeout: got busy want idle"); end
    endtask

    task automatic test_wrap();
        bit ok;
        @(negedge clk);
        req_valid_i = 3'b011;
        wait_sig(0, 10, ok);
        checks++;
        if (!ok || req_ready_o !== 3'b001)
            begin errors++; $display("FAIL wrap_grant: got %b want 001", req_ready_o); end
        req_valid_i = 3'b000;
        wait_sig(1, 30, ok);
        checks++;
        if (!ok || res_id_o !== 2'd0 || res_data_o !== RES_R0)
            begin errors++; $display("FAIL wrap_result: got id %0d data %h want id 0 data %h", res_id_o, res_data_o, RES_R0); end
        wait_sig(2, 20, ok);
    endtask

    task automatic test_round_robin();
        bit ok;
        int prev;
        logic [2:0] exp_g [4];
        exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
        prev = 0;
        @(negedge clk);
        rst_n = 1'b0;
        req_valid_i = 3'b111;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int g = 0; g < 4; g++) begin
            wait_sig(0, 40, ok);
            checks++;
            if (!ok || req_ready_o !== exp_g[g])
                begin errors++; $display("FAIL rr_grant%0d: got %b want %b", g, req_ready_o, exp_g[g]); end
            if (g > 0) begin
                checks++;
                if (cyc - prev != 19)
                    begin errors++; $display("FAIL rr_spacing%0d: got %0d want 19", g, cyc - prev); end
            end
            prev = cyc;
        end
        req_valid_i = 3'b000;
        wait_sig(2, 40, ok);
    endtask

    task automatic test_stray();
        bit ok;
        mp_model_en = 1'b0;
        @(negedge clk);
        mp_valid_i = 1'b1;
        mp_data_i  = 72'h0000000000000dead;
        @(negedge clk);
        mp_valid_i = 1'b0;
        checks++;
        if (res_valid_o !== 1'b0 || busy_o !== 1'b0 || res_data_o !== RES_R0)
            begin errors++; $display("FAIL stray_idle: got v %b busy %b data %h want 0 0 %h", res_valid_o, busy_o, res_data_o, RES_R0); end
        req_valid_i = 3'b001;
        wait_sig(0, 10, ok);
        req_valid_i = 3'b000;
        repeat (3) @(negedge clk);
        mp_valid_i = 1'b1;
        mp_data_i  = 72'h0123456789abcdef01;
        @(negedge clk);
        mp_valid_i = 1'b0;
        checks++;
        if (res_valid_o !== 1'b1 || res_data_o !== 72'h0123456789abcdef01)
            begin errors++; $display("FAIL stray_manual_result: got %b %h want 1 0123456789abcdef01", res_valid_o, res_data_o); end
        mp_valid_i = 1'b1;
        mp_data_i  = 72'hffffffffffffffffff;
        @(negedge clk);
        mp_valid_i = 1'b0;
        checks++;
        if (res_valid_o !== 1'b0 || busy_o !== 1'b1 || res_data_o !== 72'h0123456789abcdef01)
            begin errors++; $display("FAIL stray_gap: got v %b busy %b data %h want 0 1 0123456789abcdef01", res_valid_o, busy_o, res_data_o); end
        wait_sig(2, 20, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL stray_gap_exit: got busy want idle"); end
    endtask

    task automatic test_result_first();
        bit ok;
        int t_res;
        mp_model_en = 1'b1;
        @(negedge clk);
        req_valid_i = 3'b001;
        wait_sig(0, 10, ok);
        req_valid_i = 3'b000;
        repeat (13) @(negedge clk);
        req_valid_i = 3'b010;
        wait_sig(1, 10, ok);
        t_res = cyc;
        checks++;
        if (!ok || res_id_o !== 2'd0 || res_data_o !== RES_R0 || req_ready_o !== 3'b000)
            begin errors++; $display("FAIL first_result: got id %0d data %h rdy %b want 0 %h 000", res_id_o, res_data_o, req_ready_o, RES_R0); end
        wait_sig(0, 20, ok);
        checks++;
        if (!ok || req_ready_o !== 3'b010 || cyc - t_res != 5)
            begin errors++; $display("FAIL first_late_grant: got %b after %0d want 010 after 5", req_ready_o, cyc - t_res); end
        req_valid_i = 3'b000;
        wait_sig(1, 30, ok);
        checks++;
        if (!ok || res_id_o !== 2'd1 || res_data_o !== RES_R1)
            begin errors++; $display("FAIL first_second_result: got id %0d data %h want 1 %h", res_id_o, res_data_o, RES_R1); end
        wait_sig(2, 20, ok);
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit seen;
        mp_model_en = 1'b1;
        @(negedge clk);
        req_valid_i = 3'b010;
        wait_sig(0, 10, ok);
        req_valid_i = 3'b000;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || mp_data_o !== 288'd0 || res_data_o !== 72'd0 || res_id_o !== 2'd0)
            begin errors++; $display("FAIL midreset_clear: got busy %b mp %h res %h id %0d want all 0", busy_o, mp_data_o, res_data_o, res_id_o); end
        checks++;
        if (req_ready_o !== 3'b000 || mp_valid_o !== 1'b0 || res_valid_o !== 1'b0 || err_o !== 1'b0)
            begin errors++; $display("FAIL midreset_pulses: got %b %b %b %b want 000 0 0 0", req_ready_o, mp_valid_o, res_valid_o, err_o); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        req_valid_i = 3'b111;
        wait_sig(0, 10, ok);
        checks++;
        if (!ok || req_ready_o !== 3'b001)
            begin errors++; $display("FAIL midreset_next_grant: got %b want 001", req_ready_o); end
        req_valid_i = 3'b000;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (res_valid_o) seen = 1'b1;
        end
        checks++;
        if (seen)
            begin errors++; $display("FAIL midreset_stale_result: got res_valid want none"); end
        wait_sig(1, 10, ok);
        checks++;
        if (!ok || res_id_o !== 2'd0 || res_data_o !== RES_R0)
            begin errors++; $display("FAIL midreset_result: got id %0d data %h want 0 %h", res_id_o, res_data_o, RES_R0); end
        wait_sig(2, 20, ok);
    endtask

    task automatic test_timeout();
        bit ok;
        int t_iss;
        mp_model_en = 1'b0;
        @(negedge clk);
        req_valid_i = 3'b100;
        wait_sig(0, 10, ok);
        t_iss = cyc;
        checks++;
        if (!ok || req_ready_o !== 3'b100)
            begin errors++; $display("FAIL to_grant: got %b want 100", req_ready_o); end
        req_valid_i = 3'b000;
`ifdef POOL_TIMEOUT_EN
        wait_sig(3, 60, ok);
        checks++;
        if (!ok || cyc - t_iss != 33)
            begin errors++; $display("FAIL to_err_time: got %0d want 33", cyc - t_iss); end
        checks++;
        if (res_id_o !== 2'd2 || res_valid_o !== 1'b0)
            begin errors++; $display("FAIL to_err_id: got id %0d v %b want 2 0", res_id_o, res_valid_o); end
        @(negedge clk);
        checks++;
        if (err_o !== 1'b0 || busy_o !== 1'b1)
            begin errors++; $display("FAIL to_err_pulse: got %b busy %b want 0 1", err_o, busy_o); end
        wait_sig(2, 20, ok);
        req_valid_i = 3'b001;
        wait_sig(0, 10, ok);
        checks++;
        if (!ok || req_ready_o !== 3'b001)
            begin errors++; $display("FAIL to_resume: got %b want 001", req_ready_o); end
        req_valid_i = 3'b000;
        repeat (3) @(negedge clk);
`else
        ok = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (err_o || res_valid_o || !busy_o) ok = 1'b0;
        end
        checks++;
        if (!ok)
            begin errors++; $display("FAIL to_unbounded_wait: got exit from WAIT want stay"); end
`endif
        mp_valid_i = 1'b1;
        mp_data_i  = 72'h5a5a5a5a5a5a5a5a5a;
        @(negedge clk);
        mp_valid_i = 1'b0;
`ifndef POOL_TIMEOUT_EN
        checks++;
        if (res_valid_o !== 1'b1 || res_id_o !== 2'd2 || res_data_o !== 72'h5a5a5a5a5a5a5a5a5a)
            begin errors++; $display("FAIL to_late_result: got %b id %0d %h want 1 2 5a..", res_valid_o, res_id_o, res_data_o); end
`endif
        wait_sig(2, 20, ok);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc = 0;
        mp_model_en = 1'b0;
        rst_n = 1'b0;
        req_valid_i = 3'b000;
        mp_valid_i = 1'b0;
        mp_data_i = 72'd0;
        for (int r = 0; r < 3; r++)
            req_data_i[r*288 +: 288] = window(r);
        fork
            mp_model();
        join_none
        test_reset();
        test_single();
        test_wrap();
        test_round_robin();
        test_stray();
        test_result_first();
        test_reset_mid();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
